// File: rtl/eth_tx_sequencer.sv
// eth_tx_sequencer: 10BASE-T Manchester frame transmitter with end delimiter, inter-packet gap and link pulses
module eth_tx_sequencer #(
   parameter int FRAME_LEN  = 72,
   parameter int ADDR_W     = 7,
   parameter int ETD_CYCLES = 6,
   parameter int IPG_CYCLES = 192,
   parameter int NLP_PERIOD = 320000,
   parameter int NLP_WIDTH  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_send_req,
   input  logic [7:0]        i_byte,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_pos,
   output logic              o_neg,
   output logic              o_busy,
   output logic              o_done
);
   localparam int NW = $clog2(NLP_PERIOD + 1);
   localparam int CW = $clog2(IPG_CYCLES + ETD_CYCLES + NLP_WIDTH + 2);
   typedef enum logic [2:0] {IDLE, NLP, LOAD, SEND, ETD, IPG} state_t;
   state_t state, next;
   logic [NW-1:0] nlp_cnt;
   logic [CW-1:0] cnt;
   logic [3:0] phase;
   logic [ADDR_W-1:0] byte_cnt;
   logic [ADDR_W:0] addr_inc;
   logic [7:0] shreg;
   logic pending, req_any, byte_end, last_byte, reload, man;
   assign req_any   = i_send_req | pending;
   assign byte_end  = phase == 4'd15;
   assign last_byte = byte_cnt == ADDR_W'(FRAME_LEN - 1);
   assign reload    = state == SEND && byte_end && !last_byte;
   assign addr_inc  = {1'b0, byte_cnt} + (ADDR_W+1)'(2);
   always_ff @(posedge i_clk) state <= i_rst ? IDLE : next;
   // A pending request skips the idle cycle so the gap stays exactly IPG_CYCLES
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = req_any ? LOAD : (nlp_cnt == NW'(NLP_PERIOD - 1)) ? NLP : IDLE;
         NLP:     next = (cnt == CW'(NLP_WIDTH - 1)) ? (req_any ? LOAD : IDLE) : NLP;
         LOAD:    next = (cnt == CW'(1)) ? SEND : LOAD;
         SEND:    next = (byte_end && last_byte) ? ETD : SEND;
         ETD:     next = (cnt == CW'(ETD_CYCLES - 1)) ? IPG : ETD;
         IPG:     next = (cnt == CW'(IPG_CYCLES - 1)) ? (req_any ? LOAD : IDLE) : IPG;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         nlp_cnt   <= '0;
         cnt       <= '0;
         phase     <= '0;
         byte_cnt  <= '0;
         shreg     <= '0;
         o_rd_addr <= '0;
         pending   <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         nlp_cnt  <= (state == IDLE && next == IDLE) ? nlp_cnt + 1'b1 : '0;
         cnt      <= (next != state) ? '0 : cnt + 1'b1;
         phase    <= (state == SEND) ? phase + 4'd1 : 4'd0;
         byte_cnt <= (state != SEND) ? '0 : byte_end ? byte_cnt + 1'b1 : byte_cnt;
         if ((state == LOAD && cnt == CW'(1)) || reload) shreg <= i_byte;
         if (state == LOAD && cnt == '0) o_rd_addr <= ADDR_W'(1);
         else if (reload) o_rd_addr <= (addr_inc > (ADDR_W+1)'(FRAME_LEN - 1)) ? ADDR_W'(FRAME_LEN - 1) : addr_inc[ADDR_W-1:0];
         else if (state == IPG) o_rd_addr <= '0;
         pending  <= (next == LOAD && state != LOAD) ? 1'b0 : (i_send_req && state != IDLE) ? 1'b1 : pending;
         o_done   <= state == ETD && cnt == CW'(ETD_CYCLES - 2);
      end
   end
   // Even phase carries ~bit, odd phase carries bit, LSB first
   always_comb begin
      man    = phase[0] ? shreg[phase[3:1]] : ~shreg[phase[3:1]];
      o_pos  = (state == SEND) ? man : (state == NLP || state == ETD);
      o_neg  = (state == SEND) && !man;
      o_busy = state inside {LOAD, SEND, ETD, IPG};
   end
endmodule

// File: tb/tb_eth_tx_sequencer.sv
// tb_eth_tx_sequencer: directed checks of framing, Manchester coding, gap, link pulses and reset
module tb_eth_tx_sequencer;
   localparam int FL = 72;
   logic clk = 1'b0, i_rst = 1'b1, i_send_req = 1'b0;
   logic [7:0] i_byte;
   logic [6:0] o_rd_addr;
   logic o_pos, o_neg, o_busy, o_done;
   logic [7:0] rom [FL];
   logic [15:0] first16;
   int pass_cnt = 0, total = 0, cyc = 0, done_cyc = -1;

   eth_tx_sequencer #(.NLP_PERIOD(100)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_send_req(i_send_req), .i_byte(i_byte),
      .o_rd_addr(o_rd_addr), .o_pos(o_pos), .o_neg(o_neg), .o_busy(o_busy), .o_done(o_done)
   );

   always #25 clk = ~clk;
   always @(posedge clk) i_byte <= rom[o_rd_addr];

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      i_rst = 1'b1;
      i_send_req = 1'b0;
      tick;
      tick;
      i_rst = 1'b0;
      cyc = 0;
   endtask

   task automatic start_frame;
      i_send_req = 1'b1;
      tick;
      i_send_req = 1'b0;
   endtask

   // Entered in the first LOAD cycle; returns in the first cycle after the gap
   task automatic check_frame(input string nm, input int r1, input int r2);
      int e_load, e_line, e_addr, e_etd, e_ipg, bad_i, k;
      logic b, exp_pos, bad_pos;
      e_load = 0; e_line = 0; e_addr = 0; e_etd = 0; e_ipg = 0; bad_i = -1; bad_pos = 1'b0;
      done_cyc = -1;
      first16 = '0;
      if (o_busy !== 1'b1 || o_rd_addr !== 7'd0 || o_pos !== 1'b0 || o_neg !== 1'b0 || o_done !== 1'b0) e_load++;
      tick;
      if (o_busy !== 1'b1 || o_rd_addr !== 7'd1 || o_pos !== 1'b0 || o_neg !== 1'b0 || o_done !== 1'b0) e_load++;
      tick;
      for (int i = 0; i < FL * 16; i++) begin
         k = i / 16;
         b = rom[k][(i % 16) / 2];
         exp_pos = (i % 2 == 1) ? b : ~b;
         if (i < 16) first16 = {first16[14:0], o_pos};
         if (o_pos !== exp_pos || o_neg !== ~exp_pos || o_busy !== 1'b1 || o_done !== 1'b0) begin
            if (e_line == 0) begin bad_i = i; bad_pos = o_pos; end
            e_line++;
         end
         if (o_rd_addr !== 7'((k + 1 > FL - 1) ? FL - 1 : k + 1)) e_addr++;
         i_send_req = (i == r1 || i == r2);
         tick;
      end
      i_send_req = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (o_pos !== 1'b1 || o_neg !== 1'b0 || o_busy !== 1'b1 || o_done !== (j == 5)) e_etd++;
         if (o_done === 1'b1) done_cyc = cyc;
         tick;
      end
      for (int j = 0; j < 192; j++) begin
         if (o_pos !== 1'b0 || o_neg !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) e_ipg++;
         tick;
      end
      total++; if (e_load != 0) $display("FAIL %s_load: %0d bad LOAD cycles, want 0", nm, e_load); else pass_cnt++;
      total++; if (e_line != 0) $display("FAIL %s_send: %0d bad half-bits, first at %0d got pos=%b, want 0 bad", nm, e_line, bad_i, bad_pos); else pass_cnt++;
      total++; if (e_addr != 0) $display("FAIL %s_addr: %0d bad address cycles, want 0", nm, e_addr); else pass_cnt++;
      total++; if (e_etd != 0) $display("FAIL %s_etd: %0d bad ETD cycles, want 0", nm, e_etd); else pass_cnt++;
      total++; if (e_ipg != 0) $display("FAIL %s_ipg: %0d bad IPG cycles, want 0", nm, e_ipg); else pass_cnt++;
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (o_pos !== 1'b0) $display("FAIL reset_pos: got %b want 0", o_pos); else pass_cnt++;
      total++; if (o_neg !== 1'b0) $display("FAIL reset_neg: got %b want 0", o_neg); else pass_cnt++;
      total++; if (o_rd_addr !== 7'd0) $display("FAIL reset_addr: got %0d want 0", o_rd_addr); else pass_cnt++;
      total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
      total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else pass_cnt++;
   endtask

   task automatic test_frame_55;
      for (int i = 0; i < FL; i++) rom[i] = 8'h55;
      while (cyc < 10) tick;
      start_frame;
      check_frame("f55", -1, -1);
      total++; if (first16 !== 16'h6666) $display("FAIL f55_pattern: got %h want 6666", first16); else pass_cnt++;
      total++; if (done_cyc != 1170) $display("FAIL f55_done_time: got %0d want 1170", done_cyc); else pass_cnt++;
      total++; if (o_busy !== 1'b0) $display("FAIL f55_busy_low: got %b want 0 at cycle %0d", o_busy, cyc); else pass_cnt++;
      total++; if (o_rd_addr !== 7'd0) $display("FAIL f55_addr_idle: got %0d want 0", o_rd_addr); else pass_cnt++;
   endtask

   task automatic test_byte_order;
      rom[0] = 8'hD5;
      for (int i = 1; i < FL; i++) rom[i] = 8'(i * 37 + 3);
      tick;
      tick;
      start_frame;
      check_frame("d5", -1, -1);
      total++; if (first16 !== 16'h6665) $display("FAIL d5_first_byte: got %h want 6665", first16); else pass_cnt++;
      total++; if (o_busy !== 1'b0) $display("FAIL d5_busy_low: got %b want 0", o_busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int e;
      for (int i = 0; i < FL; i++) rom[i] = 8'(255 - i * 3);
      start_frame;
      check_frame("b2b_first", 400, 800);
      total++; if (o_busy !== 1'b1 || o_pos !== 1'b0) $display("FAIL b2b_reload: got busy=%b pos=%b want 1 0", o_busy, o_pos); else pass_cnt++;
      check_frame("b2b_second", -1, -1);
      e = 0;
      for (int i = 0; i < 8; i++) begin
         if (o_busy !== 1'b0) e++;
         tick;
      end
      total++; if (e != 0) $display("FAIL b2b_third_dropped: %0d busy cycles, want 0", e); else pass_cnt++;
   endtask

   task automatic test_nlp;
      int e, pulses;
      logic exp_pos, prev;
      do_reset;
      e = 0; pulses = 0; prev = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         exp_pos = (c >= 100) && ((c - 100) % 102 < 2);
         if (o_pos !== exp_pos || o_neg !== 1'b0 || o_busy !== 1'b0) e++;
         if (o_pos === 1'b1 && prev === 1'b0) pulses++;
         prev = o_pos;
         tick;
      end
      total++; if (e != 0) $display("FAIL nlp_shape: %0d bad idle cycles, want 0", e); else pass_cnt++;
      total++; if (pulses != 9) $display("FAIL nlp_count: got %0d want 9", pulses); else pass_cnt++;
      while (cyc < 1018) tick;
      total++; if (o_pos !== 1'b1) $display("FAIL nlp_tenth: got %b want 1", o_pos); else pass_cnt++;
      start_frame;
      total++; if (o_pos !== 1'b1 || o_busy !== 1'b0) $display("FAIL nlp_width: got pos=%b busy=%b want 1 0", o_pos, o_busy); else pass_cnt++;
      tick;
      check_frame("nlp_req", -1, -1);
      total++; if (o_busy !== 1'b0) $display("FAIL nlp_req_end: got %b want 0", o_busy); else pass_cnt++;
   endtask

   task automatic test_nlp_collision;
      int e;
      e = 0;
      for (int i = 0; i < 99; i++) begin
         if (o_pos !== 1'b0) e++;
         tick;
      end
      total++; if (e != 0) $display("FAIL coll_quiet: %0d pulse cycles, want 0", e); else pass_cnt++;
      start_frame;
      total++; if (o_busy !== 1'b1 || o_pos !== 1'b0) $display("FAIL coll_load: got busy=%b pos=%b want 1 0", o_busy, o_pos); else pass_cnt++;
      check_frame("coll", -1, -1);
   endtask

   task automatic test_mid_reset;
      int e;
      do_reset;
      for (int i = 0; i < FL; i++) rom[i] = 8'(i ^ 8'hA5);
      start_frame;
      tick;
      tick;
      i_send_req = 1'b1;
      tick;
      i_send_req = 1'b0;
      repeat (319) tick;
      total++; if (o_busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", o_busy); else pass_cnt++;
      i_rst = 1'b1;
      tick;
      i_rst = 1'b0;
      total++; if (o_pos !== 1'b0 || o_neg !== 1'b0) $display("FAIL rst_line: got %b/%b want 0/0", o_pos, o_neg); else pass_cnt++;
      total++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else pass_cnt++;
      total++; if (o_rd_addr !== 7'd0) $display("FAIL rst_addr: got %0d want 0", o_rd_addr); else pass_cnt++;
      e = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pos !== 1'b0 || o_neg !== 1'b0) e++;
         tick;
      end
      total++; if (e != 0) $display("FAIL rst_quiet: %0d active cycles, want 0", e); else pass_cnt++;
      start_frame;
      check_frame("rst_fresh", -1, -1);
      total++; if (o_busy !== 1'b0) $display("FAIL rst_fresh_end: got %b want 0", o_busy); else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < FL; i++) rom[i] = 8'h00;
      test_reset;
      test_frame_55;
      test_byte_order;
      test_back_to_back;
      test_nlp;
      test_nlp_collision;
      test_mid_reset;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
